// File: rtl/deposit_pkg.sv
// Shared types for the deposit sequencer: FSM states, subunit id, helpers.
package deposit_pkg;

  localparam int NUM_SU = 4;

  typedef logic [1:0] subunit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } dep_state_t;

  function automatic logic [NUM_SU-1:0] su_onehot(input subunit_t s);
    logic [NUM_SU-1:0] m;
    m    = '0;
    m[s] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin finder: first set bit of i_mask at or above i_ptr, wrapping.
module rr_pick4
  import deposit_pkg::*;
(
  input  logic [NUM_SU-1:0] i_mask,
  input  subunit_t          i_ptr,
  output logic              o_found,
  output subunit_t          o_idx
);

  subunit_t w_j;

  // Scan from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    w_j     = i_ptr;
    for (int i = NUM_SU - 1; i >= 0; i--) begin
      w_j = i_ptr + subunit_t'(i);
      if (i_mask[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/deposit_sequencer.sv
// Round-robin deposit scheduler for four subunits with RDM strobe and sticky resolved mask.
// Optional WAIT watchdog enabled by defining DEPOSIT_TIMEOUT_EN.
module deposit_sequencer
  import deposit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SU-1:0] req,
  output logic              dep_valid,
  output subunit_t          dep_subunit,
  input  logic              dep_ready,
  input  logic              dep_done,
  output logic              rdm_active,
  output subunit_t          rdm_subunit,
  output logic [NUM_SU-1:0] resolved_mask,
  output logic              all_resolved,
  output logic              timeout_err
);

  dep_state_t        r_state, w_state_nxt;
  subunit_t          r_ptr, w_ptr_nxt;
  subunit_t          r_sub, w_sub_nxt;
  logic [NUM_SU-1:0] r_pend, w_pend_nxt;
  logic [NUM_SU-1:0] r_res, w_res_nxt;
  logic [NUM_SU-1:0] w_cand;
  logic              w_found;
  subunit_t          w_pick;
  logic              w_to_hit;
  logic              w_to_fire;

  logic r_dep_valid, r_rdm_active, r_all, r_timeout;
  subunit_t r_rdm_sub;

  assign w_cand = (r_pend | req) & ~r_res;

  rr_pick4 u_pick (
    .i_mask  (w_cand),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

`ifdef DEPOSIT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Restarts from zero every time WAIT is (re)entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_to_cnt <= '0;
    else if (r_state != WAIT || w_state_nxt != WAIT) r_to_cnt <= '0;
    else                                            r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_to_hit         = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sub_nxt   = r_sub;
    w_res_nxt   = r_res;
    w_to_fire   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_sub_nxt   = w_pick;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (dep_ready) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (dep_done) begin
          w_state_nxt = REPORT;
        end else if (w_to_hit) begin
          // Abandon this subunit for now; it stays pending and is retried later.
          w_to_fire   = 1'b1;
          w_ptr_nxt   = r_sub + subunit_t'(1);
          w_state_nxt = IDLE;
        end
      end
      REPORT: begin
        w_res_nxt   = r_res | su_onehot(r_sub);
        w_ptr_nxt   = r_sub + subunit_t'(1);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Resolved subunits never re-enter the pending set.
  assign w_pend_nxt = (r_pend | req) & ~w_res_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_sub        <= '0;
      r_pend       <= '0;
      r_res        <= '0;
      r_dep_valid  <= 1'b0;
      r_rdm_active <= 1'b0;
      r_rdm_sub    <= '0;
      r_all        <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_sub        <= w_sub_nxt;
      r_pend       <= w_pend_nxt;
      r_res        <= w_res_nxt;
      r_dep_valid  <= (w_state_nxt == ISSUE);
      r_rdm_active <= (w_state_nxt == REPORT);
      r_rdm_sub    <= (w_state_nxt == REPORT) ? r_sub : '0;
      r_all        <= &w_res_nxt;
      r_timeout    <= w_to_fire;
    end
  end

  assign dep_valid     = r_dep_valid;
  assign dep_subunit   = r_sub;
  assign rdm_active    = r_rdm_active;
  assign rdm_subunit   = r_rdm_sub;
  assign resolved_mask = r_res;
  assign all_resolved  = r_all;
  assign timeout_err   = r_timeout;

endmodule
